// File: rtl/hitbox_scanner_pkg.sv
// rtl/hitbox_scanner_pkg.sv - shared types and constants for the hitbox scanner
//
// Contents:
//   COORD_W      : pixel coordinate / size width
//   hitbox_t     : packed axis-aligned box (top-left x,y plus width w, height h)
//   scan_state_t : scanner FSM state encoding
package hitbox_scanner_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } hitbox_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/hitbox_scanner_aabb_overlap.sv
// rtl/hitbox_scanner_aabb_overlap.sv - combinational strict axis-aligned box overlap test
//
// Ports:
//   ax, ay, aw, ah : first box top-left and size
//   bx, by, bw, bh : second box top-left and size
//   overlap        : 1 when the boxes share interior area (touching edges do not count)
module hitbox_scanner_aabb_overlap
    import hitbox_scanner_pkg::*;
(
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] aw,
    input  logic [COORD_W-1:0] ah,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] bw,
    input  logic [COORD_W-1:0] bh,
    output logic               overlap
);

    // Far edges are one bit wider than coordinates so a box near the
    // screen limit (e.g. x=1016, w=16) does not wrap back to a small value.
    logic [COORD_W:0] a_right;
    logic [COORD_W:0] a_bottom;
    logic [COORD_W:0] b_right;
    logic [COORD_W:0] b_bottom;
    logic             sized;

    always_comb begin
        a_right  = {1'b0, ax} + {1'b0, aw};
        a_bottom = {1'b0, ay} + {1'b0, ah};
        b_right  = {1'b0, bx} + {1'b0, bw};
        b_bottom = {1'b0, by} + {1'b0, bh};

        // Zero-size boxes never collide, whatever their position.
        sized = (aw != '0) && (ah != '0) && (bw != '0) && (bh != '0);

        overlap = sized
                  && ({1'b0, ax} < b_right)
                  && (a_right    > {1'b0, bx})
                  && ({1'b0, ay} < b_bottom)
                  && (a_bottom   > {1'b0, by});
    end

endmodule

// File: rtl/hitbox_scanner.sv
// rtl/hitbox_scanner.sv - walks an obstacle table and reports overlaps with the player box
//
// Ports:
//   Clk, Reset                 : clock, synchronous active-high reset
//   Start                      : one-cycle query request (ignored while Busy)
//   PlayerX/Y/W/H              : player hitbox, latched when a query is accepted
//   ObjAddr                    : obstacle table read address
//   ObjX/Y/W/H, ObjValid       : slot data, valid one cycle after ObjAddr
//   Busy                       : scan or drain in progress
//   Done                       : one-cycle pulse, results just updated
//   Hit, HitIdx, HitCount      : any overlap, lowest overlapping slot, overlap count
module hitbox_scanner
    import hitbox_scanner_pkg::*;
#(
    parameter int NUM_OBJ = 8,
    parameter int IDX_W   = 3
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [COORD_W-1:0] PlayerX,
    input  logic [COORD_W-1:0] PlayerY,
    input  logic [COORD_W-1:0] PlayerW,
    input  logic [COORD_W-1:0] PlayerH,
    output logic [IDX_W-1:0]   ObjAddr,
    input  logic [COORD_W-1:0] ObjX,
    input  logic [COORD_W-1:0] ObjY,
    input  logic [COORD_W-1:0] ObjW,
    input  logic [COORD_W-1:0] ObjH,
    input  logic               ObjValid,
    output logic               Busy,
    output logic               Done,
    output logic               Hit,
    output logic [IDX_W-1:0]   HitIdx,
    output logic [IDX_W:0]     HitCount
);

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_OBJ - 1);

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic             accept;

    hitbox_t          player_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cmp_idx_q;
    logic             cmp_en_q;

    logic             acc_any_q;
    logic [IDX_W-1:0] acc_first_q;
    logic [IDX_W:0]   acc_count_q;
    logic             acc_any_d;
    logic [IDX_W-1:0] acc_first_d;
    logic [IDX_W:0]   acc_count_d;

    logic             slot_hit;

    hitbox_scanner_aabb_overlap u_overlap (
        .ax      (player_q.x),
        .ay      (player_q.y),
        .aw      (player_q.w),
        .ah      (player_q.h),
        .bx      (ObjX),
        .by      (ObjY),
        .bw      (ObjW),
        .bh      (ObjH),
        .overlap (slot_hit)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SCAN;
                    accept  = 1'b1;
                end
            end
            S_SCAN: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // Back-to-back queries are accepted straight out of DONE.
                if (Start) begin
                    state_d = S_SCAN;
                    accept  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Accumulator update for the slot whose data is on the Obj* inputs now.
    // A new query and a live compare never coincide: compares only run in
    // the cycle after a SCAN cycle, and accept only fires in IDLE/DONE.
    always_comb begin
        acc_any_d   = acc_any_q;
        acc_first_d = acc_first_q;
        acc_count_d = acc_count_q;
        if (accept) begin
            acc_any_d   = 1'b0;
            acc_first_d = '0;
            acc_count_d = '0;
        end else if (cmp_en_q && ObjValid && slot_hit) begin
            if (!acc_any_q) begin
                acc_first_d = cmp_idx_q;
            end
            acc_any_d   = 1'b1;
            acc_count_d = acc_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            player_q    <= '0;
            cnt_q       <= '0;
            cmp_idx_q   <= '0;
            cmp_en_q    <= 1'b0;
            acc_any_q   <= 1'b0;
            acc_first_q <= '0;
            acc_count_q <= '0;
            Hit         <= 1'b0;
            HitIdx      <= '0;
            HitCount    <= '0;
        end else begin
            // Table data lags the address by one cycle, so the compare
            // stage works on a delayed copy of the address counter.
            cmp_en_q  <= (state_q == S_SCAN);
            cmp_idx_q <= cnt_q;

            acc_any_q   <= acc_any_d;
            acc_first_q <= acc_first_d;
            acc_count_q <= acc_count_d;

            if (accept) begin
                player_q.x <= PlayerX;
                player_q.y <= PlayerY;
                player_q.w <= PlayerW;
                player_q.h <= PlayerH;
                cnt_q      <= '0;
            end else if ((state_q == S_SCAN) && (cnt_q != LAST_ADDR)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // DRAIN holds the last slot's compare, so publish the updated
            // accumulator values rather than the registered ones.
            if (state_q == S_DRAIN) begin
                Hit      <= acc_any_d;
                HitIdx   <= acc_first_d;
                HitCount <= acc_count_d;
            end
        end
    end

    // The counter stops at the last address, so ObjAddr holds it after a scan.
    assign ObjAddr = cnt_q;
    assign Busy    = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign Done    = (state_q == S_DONE);

endmodule

// File: tb/tb_hitbox_scanner.sv
// tb/tb_hitbox_scanner.sv - directed table-driven bench for hitbox_scanner
module tb_hitbox_scanner;

    localparam int NUM_OBJ = 8;
    localparam int IDX_W   = 3;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [9:0]       PlayerX, PlayerY, PlayerW, PlayerH;
    logic [IDX_W-1:0] ObjAddr;
    logic [9:0]       ObjX, ObjY, ObjW, ObjH;
    logic             ObjValid;
    logic             Busy, Done, Hit;
    logic [IDX_W-1:0] HitIdx;
    logic [IDX_W:0]   HitCount;

    hitbox_scanner #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .PlayerX  (PlayerX),
        .PlayerY  (PlayerY),
        .PlayerW  (PlayerW),
        .PlayerH  (PlayerH),
        .ObjAddr  (ObjAddr),
        .ObjX     (ObjX),
        .ObjY     (ObjY),
        .ObjW     (ObjW),
        .ObjH     (ObjH),
        .ObjValid (ObjValid),
        .Busy     (Busy),
        .Done     (Done),
        .Hit      (Hit),
        .HitIdx   (HitIdx),
        .HitCount (HitCount)
    );

    always #5 Clk = ~Clk;

    // Obstacle table with one-cycle read latency.
    logic [9:0] tx [NUM_OBJ];
    logic [9:0] ty [NUM_OBJ];
    logic [9:0] tw [NUM_OBJ];
    logic [9:0] th [NUM_OBJ];
    logic       tv [NUM_OBJ];

    always @(posedge Clk) begin
        ObjX     <= tx[ObjAddr];
        ObjY     <= ty[ObjAddr];
        ObjW     <= tw[ObjAddr];
        ObjH     <= th[ObjAddr];
        ObjValid <= tv[ObjAddr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h, input logic v);
        tx[i] = 10'(x);
        ty[i] = 10'(y);
        tw[i] = 10'(w);
        th[i] = 10'(h);
        tv[i] = v;
    endtask

    task automatic set_far();
        for (int i = 0; i < NUM_OBJ; i++) set_slot(i, 500, 400, 8, 8, 1'b1);
    endtask

    task automatic set_player(input int x, input int y, input int w, input int h);
        PlayerX = 10'(x);
        PlayerY = 10'(y);
        PlayerW = 10'(w);
        PlayerH = 10'(h);
    endtask

    // Cycle 0 is the cycle Start is driven high; Done is expected in cycle 10.
    task automatic run_query(input string name, input int again_at, input int chg_at,
                             input int eh, input int ei, input int ec);
        int cyc;
        int done_cyc;
        done_cyc = -1;
        Start = 1'b1;
        step();
        Start = 1'b0;
        cyc = 1;
        while (cyc <= 30) begin
            Start = (cyc == again_at);
            if (cyc == chg_at) begin
                PlayerX = 10'd0;
                PlayerY = 10'd0;
            end
            if (Done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc <= NUM_OBJ) check({name, " addr"}, ObjAddr, cyc - 1);
            check({name, " busy"}, Busy, 1);
            step();
            cyc++;
        end
        Start = 1'b0;
        check({name, " done_cycle"}, done_cyc, NUM_OBJ + 2);
        check({name, " hit"}, Hit, eh);
        check({name, " hit_idx"}, HitIdx, ei);
        check({name, " hit_count"}, HitCount, ec);
        check({name, " done_busy"}, Busy, 0);
        step();
        check({name, " done_pulse_width"}, Done, 0);
    endtask

    typedef struct {
        string name;
        int px, py, pw, ph;
        int ox, oy, ow, oh;
        int slot;
        bit ov;
        bit eh;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int ndone;
        int k;

        vecs[0]  = '{"overlap_slot3",   100, 100, 16, 16,  110, 110, 16, 16, 3, 1'b1, 1'b1};
        vecs[1]  = '{"touch_right",     100, 100, 16, 16,  116, 100, 16, 16, 3, 1'b1, 1'b0};
        vecs[2]  = '{"touch_left",      100, 100, 16, 16,   84, 100, 16, 16, 2, 1'b1, 1'b0};
        vecs[3]  = '{"one_px_left",     100, 100, 16, 16,   85, 100, 16, 16, 0, 1'b1, 1'b1};
        vecs[4]  = '{"obj_w_zero",      100, 100, 16, 16,  105, 105,  0,  8, 4, 1'b1, 1'b0};
        vecs[5]  = '{"obj_h_zero",      100, 100, 16, 16,  105, 105,  8,  0, 4, 1'b1, 1'b0};
        vecs[6]  = '{"touch_bottom",    100, 100, 16, 16,  100, 116, 16, 16, 6, 1'b1, 1'b0};
        vecs[7]  = '{"inactive",        100, 100, 16, 16,  105, 105,  4,  4, 1, 1'b0, 1'b0};
        vecs[8]  = '{"edge_11bit",     1016, 470, 16,  8, 1020, 474,  4,  4, 0, 1'b1, 1'b1};
        vecs[9]  = '{"corner_px_slot7",1016, 470, 16,  8, 1023, 477,  1,  1, 7, 1'b1, 1'b1};
        vecs[10] = '{"player_w_zero",   100, 100,  0, 16,   90,  90, 30, 30, 2, 1'b1, 1'b0};
        vecs[11] = '{"contained",       100, 100, 16, 16,   50,  50,200,200, 5, 1'b1, 1'b1};

        Start = 1'b0;
        set_player(100, 100, 16, 16);
        set_far();
        Reset = 1'b1;
        step();
        step();
        check("reset busy", Busy, 0);
        check("reset done", Done, 0);
        check("reset hit", Hit, 0);
        check("reset hit_idx", HitIdx, 0);
        check("reset hit_count", HitCount, 0);
        check("reset addr", ObjAddr, 0);
        Reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            set_far();
            set_player(vecs[i].px, vecs[i].py, vecs[i].pw, vecs[i].ph);
            set_slot(vecs[i].slot, vecs[i].ox, vecs[i].oy, vecs[i].ow, vecs[i].oh, vecs[i].ov);
            run_query(vecs[i].name, -1, -1, int'(vecs[i].eh),
                      vecs[i].eh ? vecs[i].slot : 0, int'(vecs[i].eh));
            check({vecs[i].name, " addr_hold"}, ObjAddr, NUM_OBJ - 1);
        end

        // Edge touch plus zero-width slot in one scan: nothing counts.
        set_far();
        set_player(100, 100, 16, 16);
        set_slot(3, 116, 100, 16, 16, 1'b1);
        set_slot(6, 105, 105, 0, 16, 1'b1);
        run_query("touch_and_zero", -1, -1, 0, 0, 0);

        // Slots 1,2,5 overlap, slot 2 inactive; player moved away mid-scan.
        set_far();
        set_player(100, 100, 16, 16);
        set_slot(1, 110, 110, 16, 16, 1'b1);
        set_slot(2, 100, 100, 16, 16, 1'b0);
        set_slot(5, 90, 90, 20, 20, 1'b1);
        run_query("multi_latched", -1, 3, 1, 1, 2);

        // 11-bit sum case with a Start pulse while busy.
        set_far();
        set_player(1016, 470, 16, 8);
        set_slot(0, 1020, 474, 4, 4, 1'b1);
        run_query("start_while_busy", 5, -1, 1, 0, 1);

        // Every slot overlaps: count reaches NUM_OBJ.
        set_player(100, 100, 16, 16);
        for (int i = 0; i < NUM_OBJ; i++) set_slot(i, 90 + i, 95, 20, 20, 1'b1);
        run_query("all_hit", -1, -1, 1, 0, NUM_OBJ);

        // Reset for 3 cycles in the middle of a scan.
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midreset busy", Busy, 0);
            check("midreset hit", Hit, 0);
            check("midreset hit_count", HitCount, 0);
        end
        check("midreset done", Done, 0);
        check("midreset hit_idx", HitIdx, 0);
        check("midreset addr", ObjAddr, 0);
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (Done) ndone++;
        end
        check("midreset no_done", ndone, 0);

        // Back-to-back: Start held high through DONE.
        set_far();
        set_player(100, 100, 16, 16);
        set_slot(3, 110, 110, 16, 16, 1'b1);
        Start = 1'b1;
        step();
        k = 1;
        while (!Done && k < 30) begin
            step();
            k++;
        end
        check("b2b first_done_cycle", k, 10);
        check("b2b first_hit_idx", HitIdx, 3);
        set_slot(3, 500, 400, 8, 8, 1'b1);
        set_slot(6, 105, 105, 8, 8, 1'b1);
        step();
        Start = 1'b0;
        k++;
        check("b2b restart_busy", Busy, 1);
        check("b2b restart_addr", ObjAddr, 0);
        while (k < 19) begin
            step();
            k++;
        end
        check("b2b held_done", Done, 0);
        check("b2b held_hit_idx", HitIdx, 3);
        check("b2b held_hit", Hit, 1);
        step();
        check("b2b second_done", Done, 1);
        check("b2b second_hit_idx", HitIdx, 6);
        check("b2b second_hit_count", HitCount, 1);
        step();
        check("b2b back_to_idle", Busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
